// File: rtl/cia_pkg.sv
// cia_pkg: shared CIA register types, SDR address and sequencer state encoding
package cia_pkg;
  typedef logic [3:0] reg4_t;
  typedef logic [7:0] reg8_t;
  localparam reg4_t SDR_ADDR = 4'hC;
  typedef enum logic {SEQ_IDLE, SEQ_ISSUE} seq_state_t;
endpackage

// File: rtl/cia_seq_fifo.sv
// cia_seq_fifo: 8-bit synchronous FIFO, valid/ready on both sides, power-of-2 depth
module cia_seq_fifo
  import cia_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready
);
  localparam int AW = $clog2(DEPTH);
  reg8_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, pop;
  assign in_ready = cnt != (AW+1)'(DEPTH);
  assign out_valid = cnt != '0;
  assign out_data = mem[rp];
  assign push = in_valid & in_ready;
  assign pop = out_ready & out_valid;
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end
endmodule

// File: rtl/cia_sdr_sequencer.sv
// cia_sdr_sequencer: streams host bytes into SDR in free write slots; CPU always wins the port.
// Optional RX capture FIFO built when CIA_SEQ_RX_EN is defined.
module cia_sdr_sequencer
  import cia_pkg::*;
#(
  parameter int TXDEPTH = 4,
  parameter int RXDEPTH = 4
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_dn,
  input  logic       cpu_we,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_data,
  input  logic       txmode,
  input  logic       sp_int,
  input  logic [7:0] sdr,
  output logic       we,
  output logic [3:0] addr,
  output logic [7:0] data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       busy,
  output logic [2:0] stat
);
  seq_state_t state, state_nx;
  logic [1:0] inflight, inflight_nx;
  logic txmode_prev, sp_int_prev, mode_chg, sp_edge;
  logic seq_wr, cpu_sdr_wr, inc, dec;
  logic tx_nempty, tx_unused, cpu_sdr_hit, rx_flag;
  reg8_t tx_head;
  reg4_t cpu_a;
  assign cpu_a = cpu_addr;
  assign mode_chg = txmode ^ txmode_prev;
  assign sp_edge = sp_int & ~sp_int_prev;
  assign seq_wr = (state == SEQ_ISSUE) & phi2_dn & ~cpu_we & txmode;
  assign cpu_sdr_wr = cpu_we & (cpu_a == SDR_ADDR) & txmode;
  assign inc = seq_wr | cpu_sdr_wr;
  assign dec = sp_edge & txmode;
  assign we = cpu_we | seq_wr;
  assign addr = seq_wr ? SDR_ADDR : cpu_a;
  assign data = seq_wr ? tx_head : cpu_data;
  assign busy = tx_nempty | (inflight != 2'd0);
  assign stat = {rx_flag, cpu_sdr_hit, tx_unused};
  cia_seq_fifo #(.DEPTH(TXDEPTH)) u_tx (
    .clk(clk), .res_n(res_n),
    .in_valid(tx_valid), .in_data(tx_data), .in_ready(tx_ready),
    .out_valid(tx_nempty), .out_data(tx_head), .out_ready(seq_wr)
  );
  always_comb begin
    inflight_nx = mode_chg ? 2'd0 :
                  (inc & ~dec) ? ((inflight == 2'd2) ? 2'd2 : inflight + 2'd1) :
                  (dec & ~inc & (inflight != 2'd0)) ? inflight - 2'd1 : inflight;
    state_nx = (mode_chg | ~txmode) ? SEQ_IDLE :
               (state == SEQ_IDLE) ? ((tx_nempty & (inflight < 2'd2)) ? SEQ_ISSUE : SEQ_IDLE) :
               (seq_wr ? SEQ_IDLE : SEQ_ISSUE);
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= SEQ_IDLE;
      inflight <= 2'd0;
      txmode_prev <= 1'b0;
      sp_int_prev <= 1'b0;
      tx_unused <= 1'b0;
      cpu_sdr_hit <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= inflight_nx;
      txmode_prev <= txmode;
      sp_int_prev <= sp_int;
      tx_unused <= tx_unused | (dec & (inflight == 2'd0));
      cpu_sdr_hit <= cpu_sdr_hit | cpu_sdr_wr;
    end
  end
`ifdef CIA_SEQ_RX_EN
  logic rx_pend, rx_cap, rx_push, rx_in_ready;
  assign rx_push = rx_cap & ~mode_chg;
  cia_seq_fifo #(.DEPTH(RXDEPTH)) u_rx (
    .clk(clk), .res_n(res_n),
    .in_valid(rx_push), .in_data(sdr), .in_ready(rx_in_ready),
    .out_valid(rx_valid), .out_data(rx_data), .out_ready(rx_ready)
  );
  // SDR holds the received byte one clk after the phi2_dn that follows the shift-done edge
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_pend <= 1'b0;
      rx_cap <= 1'b0;
      rx_flag <= 1'b0;
    end else begin
      rx_pend <= ~mode_chg & ((rx_pend & ~phi2_dn) | (sp_edge & ~txmode));
      rx_cap <= ~mode_chg & rx_pend & phi2_dn;
      rx_flag <= rx_flag | (rx_push & ~rx_in_ready);
    end
  end
`else
  localparam int unused_rxdepth = RXDEPTH;
  logic unused_rx;
  assign unused_rx = ^{rx_ready, sdr};
  assign rx_valid = 1'b0;
  assign rx_data = 8'h00;
  assign rx_flag = 1'b0;
`endif
endmodule

// File: tb/tb_cia_sdr_sequencer.sv
// tb_cia_sdr_sequencer: directed scenarios plus random traffic checked against a queue-based model
module tb_cia_sdr_sequencer;
  localparam int TXD = 4;
  localparam int RXD = 4;
  logic clk = 0, res_n = 0, phi2_dn = 0, cpu_we = 0, txmode = 0, sp_int = 0;
  logic [3:0] cpu_addr = 0;
  logic [7:0] cpu_data = 0, sdr = 0, tx_data = 0;
  logic tx_valid = 0, rx_ready = 0;
  logic we, tx_ready, rx_valid, busy;
  logic [3:0] addr;
  logic [7:0] data, rx_data;
  logic [2:0] stat;
  always #5 clk = ~clk;
  cia_sdr_sequencer #(.TXDEPTH(TXD), .RXDEPTH(RXD)) dut (
    .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .txmode(txmode), .sp_int(sp_int), .sdr(sdr), .we(we), .addr(addr),
    .data(data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .busy(busy), .stat(stat)
  );
  int errors = 0, checks = 0, cyc = 0, base = 0;
  bit rnd_phi = 0;
  logic [7:0] txq[$], rxq[$], wlog[$];
  int infl;
  bit armed, m_prev, s_prev, rx_wait, rx_take, f_unused, f_hit, f_ovf;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    txq.delete(); rxq.delete();
    infl = 0; armed = 0; m_prev = 0; s_prev = 0; rx_wait = 0; rx_take = 0;
    f_unused = 0; f_hit = 0; f_ovf = 0;
  endtask
  function automatic logic [7:0] wl(input int i);
    return (i < wlog.size()) ? wlog[i] : 8'hxx;
  endfunction
  task automatic tick();
    bit seqw, flip, rise, up, dn, cpu_sdr, exp_rxv;
    int n_old, i_old, r_old;
    phi2_dn = rnd_phi ? ($urandom_range(2) == 0) : (cyc % 4 == 3);
    cyc++;
    @(negedge clk);
    seqw = armed && phi2_dn && !cpu_we && txmode;
`ifdef CIA_SEQ_RX_EN
    exp_rxv = rxq.size() != 0;
`else
    exp_rxv = 0;
`endif
    check("bus", {we, addr, data}, {cpu_we | seqw, seqw ? 4'hC : cpu_addr, seqw ? txq[0] : cpu_data});
    check("status", {tx_ready, rx_valid, rx_valid ? rx_data : 8'h00, busy, stat},
          {txq.size() < TXD, exp_rxv, exp_rxv ? rxq[0] : 8'h00, (txq.size() != 0) || (infl != 0),
           f_ovf, f_hit, f_unused});
    if (we && addr == 4'hC && !cpu_we) wlog.push_back(data);
    flip = txmode != m_prev;
    rise = sp_int && !s_prev;
    cpu_sdr = cpu_we && cpu_addr == 4'hC && txmode;
    up = seqw || cpu_sdr;
    dn = rise && txmode;
    n_old = txq.size();
    i_old = infl;
    if (dn && i_old == 0) f_unused = 1;
    if (cpu_sdr) f_hit = 1;
    if (flip) infl = 0;
    else if (up && !dn) infl = (i_old == 2) ? 2 : i_old + 1;
    else if (dn && !up && i_old > 0) infl = i_old - 1;
    armed = (flip || !txmode) ? 0 : (!armed ? (n_old > 0 && i_old < 2) : !seqw);
    if (seqw) void'(txq.pop_front());
    if (tx_valid && n_old < TXD) txq.push_back(tx_data);
`ifdef CIA_SEQ_RX_EN
    r_old = rxq.size();
    if (rx_ready && r_old > 0) void'(rxq.pop_front());
    if (rx_take && !flip) begin
      if (r_old < RXD) rxq.push_back(sdr);
      else f_ovf = 1;
    end
    rx_take = !flip && rx_wait && phi2_dn;
    rx_wait = !flip && ((rx_wait && !phi2_dn) || (rise && !txmode));
`else
    r_old = 0;
`endif
    m_prev = txmode;
    s_prev = sp_int;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic push(input logic [7:0] b);
    tx_valid = 1; tx_data = b;
    tick();
    tx_valid = 0;
  endtask
  task automatic pulse_sp();
    sp_int = 1; tick();
    sp_int = 0; tick();
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", {we, addr, data, tx_ready, rx_valid, busy, stat}, {1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 3'b000});
    res_n = 1;
    // 1: two back-to-back writes, third held by full double buffer
    txmode = 1; run(2);
    base = wlog.size();
    push(8'hA5); push(8'h3C); run(12);
    check("t1_count", wlog.size() - base, 2);
    check("t1_first", wl(base), 8'hA5);
    check("t1_second", wl(base + 1), 8'h3C);
    push(8'h77); run(12);
    check("t1_held", wlog.size() - base, 2);
    pulse_sp(); run(10);
    check("t1_third", wl(base + 2), 8'h77);
    pulse_sp(); pulse_sp(); run(2);
    check("t1_idle", busy, 1'b0);
    // 2: CPU steals the sequencer's slot
    base = wlog.size();
    push(8'hA5); tick();
    while (cyc % 4 != 3) tick();
    cpu_we = 1; cpu_addr = 4'h4; cpu_data = 8'h99;
    tick();
    cpu_we = 0; cpu_addr = 0; cpu_data = 0;
    check("t2_stolen", wlog.size() - base, 0);
    run(8);
    check("t2_late", wl(base), 8'hA5);
    // 3: CPU SDR write raises inflight to 2
    cpu_we = 1; cpu_addr = 4'hC; cpu_data = 8'h11; tick();
    cpu_we = 0; cpu_addr = 0; cpu_data = 0; tick();
    check("t3_hit", stat[1], 1'b1);
    // 4: txmode toggle drops inflight, keeps bytes
    base = wlog.size();
    push(8'h21); push(8'h22); run(8);
    check("t4_blocked", wlog.size() - base, 0);
    txmode = 0; run(8);
    check("t4_off", wlog.size() - base, 0);
    txmode = 1; run(16);
    check("t4_r0", wl(base), 8'h21);
    check("t4_r1", wl(base + 1), 8'h22);
    pulse_sp(); pulse_sp(); pulse_sp();
    check("t4_unused", stat[0], 1'b1);
    // 5: RX capture and overflow
    txmode = 0; run(2);
    sdr = 8'h5A; pulse_sp(); run(6);
`ifdef CIA_SEQ_RX_EN
    check("t5_valid", rx_valid, 1'b1);
    check("t5_data", rx_data, 8'h5A);
`endif
    for (int i = 0; i < RXD; i++) begin
      sdr = 8'h60 + 8'(i); pulse_sp(); run(6);
    end
`ifdef CIA_SEQ_RX_EN
    check("t5_ovf", stat[2], 1'b1);
    for (int i = 0; i < RXD; i++) begin
      check("t5_read", rx_data, (i == 0) ? 8'h5A : 8'h60 + 8'(i - 1));
      rx_ready = 1; tick(); rx_ready = 0;
    end
`endif
    check("t5_empty", {rx_valid, stat[2]},
`ifdef CIA_SEQ_RX_EN
          2'b01);
`else
          2'b00);
`endif
    // random traffic
    rnd_phi = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(40) == 0) txmode = ~txmode;
      sp_int = ($urandom_range(5) == 0);
      cpu_we = ($urandom_range(7) == 0);
      cpu_addr = ($urandom_range(2) == 0) ? 4'hC : 4'($urandom);
      cpu_data = 8'($urandom);
      tx_valid = $urandom_range(1);
      tx_data = 8'($urandom);
      rx_ready = ($urandom_range(3) == 0);
      sdr = 8'($urandom);
      tick();
    end
    // 6: async reset during ISSUE
    rnd_phi = 0; cpu_we = 0; cpu_addr = 0; cpu_data = 0; tx_valid = 0; rx_ready = 0; sp_int = 0;
    txmode = 1; run(4);
    for (int k = 0; k < 60 && !armed; k++) begin
      sp_int = ~sp_int;
      tx_valid = txq.size() == 0;
      tx_data = 8'hBE;
      tick();
    end
    sp_int = 0; tx_valid = 0;
    #2 res_n = 0;
    #1 check("t6_reset", {we, addr, data, tx_ready, rx_valid, busy, stat},
                         {1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 3'b000});
    model_reset();
    base = wlog.size();
    @(posedge clk);
    #1 res_n = 1;
    run(16);
    check("t6_nowrite", wlog.size() - base, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
